// File: rtl/sfp_pkg.sv
// Shared definitions for the psum normalizer: FSM state encoding and
// datapath widths used by sfp_norm and sfp_lane_div.
package sfp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC,
    S_EXCH,
    S_DIV,
    S_DONE
  } state_e;

  // 8 lanes of |-2048| = 16384 fit exactly in 15 bits.
  localparam int unsigned ACC_W     = 15;
  localparam int unsigned SUM_W     = 16;
  localparam int unsigned SHIFT_DEF = 7;

endpackage

// File: rtl/sfp_lane_div.sv
// Single-lane signed divider shared across all lanes of sfp_norm.
// Ports:
//   lane_i    - signed lane value (BW bits, two's complement)
//   divisor_i - unsigned divisor (DW bits)
//   quot_o    - low BW bits of lane_i / divisor_i, truncated toward zero;
//               forced to zero when divisor_i is zero
module sfp_lane_div #(
  parameter int unsigned BW = 12,
  parameter int unsigned DW = 16
) (
  input  logic [BW-1:0] lane_i,
  input  logic [DW-1:0] divisor_i,
  output logic [BW-1:0] quot_o
);

  logic signed [DW:0] num;
  logic signed [DW:0] den;

  // The divisor is a sum of magnitudes, so it is zero-extended to stay
  // positive; the lane is sign-extended to the same width.
  assign num = {{(DW + 1 - BW){lane_i[BW-1]}}, lane_i};
  assign den = {1'b0, divisor_i};

  always_comb begin
    quot_o = '0;
    if (divisor_i != '0) begin
      quot_o = BW'(num / den);
    end
  end

endmodule

// File: rtl/sfp_norm.sv
// Psum normalizer: captures a vector of signed psum lanes, accumulates the
// lane magnitudes, exchanges a scaled sum with a peer core, then divides
// every lane by the combined sum, one lane per cycle.
// Ports:
//   clk, reset               - clock (rising edge), synchronous active-low reset
//   sfp_in/in_valid/in_ready - input lane vector and handshake
//   sum_out/sum_out_valid    - this core's scaled magnitude sum to the peer
//   sum_in/sum_in_valid      - peer core's scaled sum
//   sfp_out/out_valid/out_ready - normalized lane vector and handshake
//   div_zero                 - combined divisor was zero for this result
module sfp_norm
  import sfp_pkg::*;
#(
  parameter int unsigned bw_psum = 12,
  parameter int unsigned col     = 8,
  parameter int unsigned shift   = SHIFT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [bw_psum*col-1:0]   sfp_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [SUM_W-1:0]         sum_out,
  output logic                     sum_out_valid,
  input  logic [SUM_W-1:0]         sum_in,
  input  logic                     sum_in_valid,
  output logic [bw_psum*col-1:0]   sfp_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     div_zero
);

  localparam int unsigned CNT_W = (col > 1) ? $clog2(col) : 1;

  state_e                   state_q, state_d;
  logic [bw_psum*col-1:0]   data_q, data_d;
  logic [bw_psum*col-1:0]   sfp_q, sfp_d;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic [SUM_W-1:0]         div_q, div_d;
  logic                     dz_q, dz_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic [bw_psum-1:0]       lane;
  logic [bw_psum-1:0]       lane_abs;
  logic [bw_psum-1:0]       quot;
  logic [SUM_W-1:0]         exch_sum;
  logic                     last_lane;

  assign lane      = data_q[cnt_q*bw_psum +: bw_psum];
  // Negating the most negative lane wraps back to the same bit pattern,
  // which read as unsigned is exactly its magnitude.
  assign lane_abs  = lane[bw_psum-1] ? -lane : lane;
  assign last_lane = (cnt_q == CNT_W'(col - 1));
  assign sum_out   = SUM_W'(acc_q >> shift);
  assign exch_sum  = sum_out + sum_in;

  sfp_lane_div #(
    .BW(bw_psum),
    .DW(SUM_W)
  ) u_lane_div (
    .lane_i   (lane),
    .divisor_i(div_q),
    .quot_o   (quot)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sfp_d   = sfp_q;
    acc_d   = acc_q;
    div_d   = div_q;
    dz_d    = dz_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d  = sfp_in;
          acc_d   = '0;
          cnt_d   = '0;
          dz_d    = 1'b0;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        acc_d = acc_q + ACC_W'(lane_abs);
        if (last_lane) begin
          cnt_d   = '0;
          state_d = S_EXCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_EXCH: begin
        if (sum_in_valid) begin
          div_d   = exch_sum;
          dz_d    = (exch_sum == '0);
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        sfp_d[cnt_q*bw_psum +: bw_psum] = quot;
        if (last_lane) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      sfp_q   <= '0;
      acc_q   <= '0;
      div_q   <= '0;
      dz_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sfp_q   <= sfp_d;
      acc_q   <= acc_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status outputs are gated by reset so they read low while it is held,
  // even before the first reset edge has been seen.
  assign in_ready      = reset && (state_q == S_IDLE);
  assign sum_out_valid = reset && (state_q == S_EXCH);
  assign out_valid     = reset && (state_q == S_DONE);
  assign div_zero      = reset && dz_q;
  assign sfp_out       = sfp_q;

endmodule

// File: tb/tb_sfp_norm.sv
module tb_sfp_norm;
  import sfp_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [95:0] sfp_in;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] sum_out;
  logic        sum_out_valid;
  logic [15:0] sum_in;
  logic        sum_in_valid;
  logic [95:0] sfp_out;
  logic        out_valid;
  logic        out_ready;
  logic        div_zero;

  int nchk  = 0;
  int nmiss = 0;

  always #5 clk = ~clk;

  sfp_norm #(.bw_psum(12), .col(8), .shift(7)) dut (
    .clk          (clk),
    .reset        (reset),
    .sfp_in       (sfp_in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .sum_out      (sum_out),
    .sum_out_valid(sum_out_valid),
    .sum_in       (sum_in),
    .sum_in_valid (sum_in_valid),
    .sfp_out      (sfp_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .div_zero     (div_zero)
  );

  typedef struct {
    logic [95:0] lanes;
    logic [15:0] sin;
    logic [15:0] esum;
    logic [95:0] eout;
    logic        edz;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nmiss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] pack8(input logic [11:0] a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic wait_ready(input string tag);
    int t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " in_ready"}, 128'(in_ready), 128'(1));
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic early;
    @(negedge clk);
    wait_ready(tag);
    sfp_in       = v.lanes;
    sum_in       = v.sin;
    sum_in_valid = 1'b1;
    out_ready    = 1'b1;
    in_valid     = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    early = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk);
      #1;
      if (k == 8) begin
        chk({tag, " sum_out"}, 128'(sum_out), 128'(v.esum));
        chk({tag, " sum_out_valid"}, 128'(sum_out_valid), 128'(1));
      end
      if (k < 17 && out_valid) early = 1'b1;
    end
    chk({tag, " latency"}, 128'({early, out_valid}), 128'(2'b01));
    chk({tag, " sfp_out"}, 128'(sfp_out), 128'(v.eout));
    chk({tag, " div_zero"}, 128'(div_zero), 128'(v.edz));
    @(posedge clk);
    #1;
    chk({tag, " accepted"}, 128'({out_valid, in_ready}), 128'(2'b01));
  endtask

  initial begin
    logic [15:0] so;
    logic [95:0] held;
    logic        steady;
    int          t;

    vt[0] = '{{8{12'h010}}, 16'd1,   16'd1,   {8{12'h008}}, 1'b0};
    vt[1] = '{{8{12'hF00}}, 16'd16,  16'd16,  {8{12'hFF8}}, 1'b0};
    vt[2] = '{{8{12'h800}}, 16'd128, 16'd128, {8{12'hFF8}}, 1'b0};
    vt[3] = '{pack8(12'hF9C, 0, 0, 0, 0, 0, 0, 0), 16'd3, 16'd0,
              pack8(12'hFDF, 0, 0, 0, 0, 0, 0, 0), 1'b0};
    vt[4] = '{{8{12'h005}}, 16'd0,   16'd0,   96'h0,        1'b1};
    // |300|+|-300|+1000+1+0+2047+2047+7 = 5702, >>7 = 44; divisor 64
    vt[5] = '{pack8(12'h12C, 12'hED4, 12'h3E8, 12'hFFF, 12'h000, 12'h7FF, 12'h801, 12'h007),
              16'd20, 16'd44,
              pack8(12'h004, 12'hFFC, 12'h00F, 12'h000, 12'h000, 12'h01F, 12'hFE1, 12'h000),
              1'b0};

    reset = 1'b0; in_valid = 1'b0; sfp_in = '0; sum_in = '0;
    sum_in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", 128'({in_ready, out_valid, sum_out_valid, div_zero, sum_out, sfp_out}), 128'(0));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready after reset", 128'(in_ready), 128'(1));

    for (int i = 0; i < 6; i++) begin
      run_vec(vt[i], $sformatf("vec%0d", i));
    end

    // Peer sum withheld, then output held back by the consumer.
    @(negedge clk);
    wait_ready("stall");
    sfp_in = vt[0].lanes; sum_in = 16'd1; sum_in_valid = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    so = sum_out;
    chk("stall sum_out", 128'(so), 128'(1));
    steady = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (dut.state_q != S_EXCH || sum_out !== so || sum_out_valid !== 1'b1) steady = 1'b0;
    end
    chk("exch hold", 128'(steady), 128'(1));
    sum_in_valid = 1'b1;
    t = 0;
    while (!out_valid && t < 30) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("stall out_valid", 128'(out_valid), 128'(1));
    chk("stall sfp_out", 128'(sfp_out), 128'(vt[0].eout));
    held = sfp_out;
    steady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || sfp_out !== held) steady = 1'b0;
    end
    chk("done hold", 128'(steady), 128'(1));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall accepted", 128'(out_valid), 128'(0));

    // Reset asserted in the third DIV cycle.
    @(negedge clk);
    wait_ready("rst");
    sfp_in = vt[0].lanes; sum_in = 16'd1; sum_in_valid = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    chk("mid-div state", 128'(dut.state_q), 128'(S_DIV));
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mid-div reset state", 128'(dut.state_q), 128'(S_IDLE));
    chk("mid-div reset outputs",
        128'({in_ready, out_valid, sum_out_valid, div_zero, sum_out, sfp_out}), 128'(0));
    @(negedge clk);
    reset = 1'b1;
    run_vec(vt[1], "post-reset");

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nmiss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sfp_norm.md
SFP_NORM -- requirements
Module: sfp_norm

Interface
REQ-001 Parameters (name, default, meaning): bw_psum, 12, psum lane width; col, 8, lanes per vector; shift, 7, sum right-shift.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: sole clock, rising edge.
- reset, in, 1: synchronous, active-low reset.
- sfp_in, in, bw_psum*col: signed psum lanes from pmem; lane i at bits [bw_psum*(i+1)-1 : bw_psum*i].
- in_valid, in, 1 / in_ready, out, 1: input handshake.
- sum_out, out, 16: this core's scaled sum.
- sum_out_valid, out, 1: sum_out valid.
- sum_in, in, 16 / sum_in_valid, in, 1: peer core's sum_out / sum_out_valid.
- sfp_out, out, bw_psum*col: normalized signed lanes.
- out_valid, out, 1 / out_ready, in, 1: output handshake.
- div_zero, out, 1: divisor was zero for the current result.

Function
REQ-003 The FSM shall have states IDLE, ACC, EXCH, DIV and DONE; no other state is reachable.
REQ-004 IDLE shall assert in_ready; when in_valid=1 at an edge, it shall capture sfp_in, clear the accumulator and lane counter, and go to ACC. All other states shall hold in_ready=0.
REQ-005 ACC shall add |lane[k]| to a 15-bit unsigned accumulator, one lane per cycle, k=0..col-1; after lane col-1 it shall go to EXCH. |-2048| shall be 2048, with no saturation.
REQ-006 sum_out shall equal accumulator>>shift, zero-extended to 16 bits, and shall stay stable outside IDLE/ACC.
REQ-007 EXCH shall assert sum_out_valid. At an edge where sum_in_valid=1, it shall register divisor = sum_out + sum_in (16-bit, wrap) and go to DIV. While sum_in_valid=0 it shall stay in EXCH.
REQ-008 DIV shall compute out_lane[k] = lane[k] / divisor, one lane per cycle, k=0..col-1. Division is signed, truncates toward zero, and the result is taken as its low bw_psum bits.
REQ-009 If divisor=0, every out_lane shall be 0 and div_zero shall be set until the next capture.
REQ-010 After lane col-1, DIV shall go to DONE. DONE shall assert out_valid with sfp_out stable. At an edge with out_ready=1 it shall go to IDLE. in_ready shall not rise in the same cycle the output is accepted.
REQ-011 Latency: with in_valid accepted at edge N and sum_in_valid already high, EXCH exits at edge N+9 and out_valid is high in the cycle after edge N+17.
REQ-012 sfp_out shall be a single register, updated lane-by-lane in DIV only. Its value is meaningful only while out_valid=1.
REQ-013 Two instances exchanging sums (sum_out -> peer sum_in) shall never deadlock: each holds its valid until its own EXCH exit.

Reset
REQ-014 reset=0 at any clock edge, in any state including mid-ACC or mid-DIV, shall force IDLE and zero sfp_out, sum_out, the accumulator, the divisor and the lane counter.
REQ-015 During reset, out_valid, sum_out_valid, div_zero and in_ready shall be 0. in_ready shall be 1 from the first edge with reset=1.

Structure
REQ-016 A shared package sfp_pkg shall hold the FSM state enum, the accumulator width (15), the exchange-sum width (16) and the default shift (7).
REQ-017 Single-lane signed division with the zero-divisor rule shall live in one sub-module, sfp_lane_div, instantiated once and time-multiplexed over lanes.

Verification
REQ-018 All lanes 0x010, sum_in=1 with sum_in_valid high -> sum_out=1, every lane 0x008, div_zero=0, out_valid in the cycle after edge N+17.
REQ-019 All lanes -256 (0xF00), sum_in=16 -> sum_out=16, every lane 0xFF8.
REQ-020 All lanes -2048 (0x800), sum_in=128 -> sum_out=128, divisor 256, every lane 0xFF8. Checks that the accumulator does not overflow.
REQ-021 Lane0=-100, others 0, sum_in=3 -> sum_out=0, lane0=-33 (0xFDF), others 0. Lanes all 5 with sum_in=0 -> all lanes 0, div_zero=1.
REQ-022 Hold sum_in_valid low 5 cycles -> FSM stays in EXCH with sum_out and sum_out_valid steady. Hold out_ready low 4 cycles -> out_valid and sfp_out steady.
REQ-023 Drive reset=0 in the 3rd DIV cycle -> next cycle state is IDLE, all outputs 0, in_ready=0. After release a fresh vector completes correctly.
